pwm_len_capture: RTL and testbench



---
 rtl/pwm_len_pkg.sv | 24 ++
 rtl/us_tick_gen.sv | 25 ++
 rtl/pwm_len_capture.sv | 154 +++++++++++++++
 tb/tb_pwm_len_capture.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pwm_len_pkg.sv
// Shared constants, FSM encoding and a saturating increment for the PWM
// length generator/capture pair.
package pwm_len_pkg;

  localparam int PWM_LEN_W       = 16;
  localparam int PWM_CLK_DIV_DEF = 50;
  localparam int PWM_PERIOD_US   = 10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_t;

  // Microsecond counters stick at all-ones rather than wrapping.
  function automatic logic [PWM_LEN_W-1:0] sat_inc(input logic [PWM_LEN_W-1:0] v,
                                                   input logic                 en);
    logic [PWM_LEN_W-1:0] r;
    r = v;
    if (en && (v != {PWM_LEN_W{1'b1}})) r = v + PWM_LEN_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLK_DIV clocks, restartable
// through clr so a measurement can be phase-aligned to an input edge.
module us_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr)     cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/pwm_len_capture.sv
// Measures high time and rise-to-rise period of a PWM input in microseconds.
// Define PWM_LEN_CAPTURE_FILTER_EN to insert a FILTER_CYC-sample glitch filter.
module pwm_len_capture
  import pwm_len_pkg::*;
#(
  parameter int CLK_DIV    = PWM_CLK_DIV_DEF,
  parameter int TIMEOUT_US = 25000,
  parameter int FILTER_CYC = 4
) (
  input  logic                 clk0,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  output logic [PWM_LEN_W-1:0] length,
  output logic                 length_valid,
  output logic [PWM_LEN_W-1:0] period,
  output logic                 period_valid,
  output logic                 timeout
);

`ifdef PWM_LEN_CAPTURE_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // Edges produced while the pipeline still holds reset zeros are not real.
  localparam int PRIME_CYC = 4 + (FILTER_EN ? FILTER_CYC : 0);
  localparam int PCW       = $clog2(PRIME_CYC + 1);
  localparam logic [PWM_LEN_W-1:0] TO_LAST = PWM_LEN_W'(TIMEOUT_US - 1);

  logic           sync1, sync2, lvl, lvl_d;
  logic           rise_q, fall_q;
  logic [PCW-1:0] prime_cnt;
  logic           primed, rise_acc, fall_acc, edge_acc, tick, timeout_hit;
  pwm_state_t     state;
  logic [PWM_LEN_W-1:0] high_cnt, per_cnt;

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_LEN_CAPTURE_FILTER_EN
  localparam int FCW = $clog2(FILTER_CYC + 1);
  logic [FCW-1:0] filt_cnt;
  logic           filt;

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      filt     <= 1'b0;
      filt_cnt <= '0;
    end else if (sync2 != filt) begin
      if (filt_cnt == FCW'(FILTER_CYC - 1)) begin
        filt     <= sync2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      lvl_d     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      prime_cnt <= '0;
    end else begin
      lvl_d  <= lvl;
      rise_q <= lvl & ~lvl_d;
      fall_q <= ~lvl & lvl_d;
      if (!primed) prime_cnt <= prime_cnt + PCW'(1);
    end
  end

  assign primed      = (prime_cnt == PCW'(PRIME_CYC));
  assign rise_acc    = rise_q & primed;
  assign fall_acc    = fall_q & primed & (state == HIGH);
  assign edge_acc    = rise_acc | fall_acc;
  assign timeout_hit = tick & (per_cnt >= TO_LAST);

  us_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk0),
    .rst_n (rst_n),
    .clr   (edge_acc),
    .tick  (tick)
  );

  // The pending tick is folded into captured values so the result is
  // floor(cycles / CLK_DIV) even when the edge lands on a tick boundary.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state        <= IDLE;
      length       <= '0;
      period       <= '0;
      length_valid <= 1'b0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      high_cnt     <= '0;
      per_cnt      <= '0;
    end else begin
      length_valid <= 1'b0;
      period_valid <= 1'b0;
      high_cnt     <= sat_inc(high_cnt, tick);
      per_cnt      <= sat_inc(per_cnt, tick);
      case (state)
        IDLE: begin
          if (rise_acc) begin
            high_cnt <= '0;
            per_cnt  <= '0;
            timeout  <= 1'b0;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (fall_acc) begin
            length       <= sat_inc(high_cnt, tick);
            length_valid <= 1'b1;
            state        <= LOW;
          end else if (timeout_hit) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        LOW: begin
          if (rise_acc) begin
            period       <= sat_inc(per_cnt, tick);
            period_valid <= 1'b1;
            high_cnt     <= '0;
            per_cnt      <= '0;
            state        <= HIGH;
          end else if (timeout_hit) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_len_capture.sv
// Directed bench for pwm_len_capture at a scaled-down clock division
// (8 clk0 per us, 500 us timeout) so whole frames fit in a short run.
module tb_pwm_len_capture;

`ifdef PWM_LEN_CAPTURE_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk0 = 1'b0;
  logic        rst_n;
  logic        pwm_in;
  logic [15:0] length, period;
  logic        length_valid, period_valid, timeout;

  int asserts = 0;
  int fails   = 0;
  int len_q[$];
  int per_q[$];
  logic prev_lv = 1'b0;
  logic prev_pv = 1'b0;

  typedef struct {
    int high_cyc;
    int low_cyc;
    int exp_len;
    int exp_per;
  } vec_t;

  vec_t vecs[6];

  pwm_len_capture #(.CLK_DIV(8), .TIMEOUT_US(500), .FILTER_CYC(4)) dut (
    .clk0         (clk0),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .length       (length),
    .length_valid (length_valid),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout)
  );

  always #5 clk0 = ~clk0;

  // Collect every strobe and insist each is isolated and never paired.
  always @(negedge clk0) begin
    if (length_valid) len_q.push_back(int'(length));
    if (period_valid) per_q.push_back(int'(period));
    if (length_valid || period_valid) begin
      asserts++;
      if ((length_valid && period_valid) || (length_valid && prev_lv) ||
          (period_valid && prev_pv)) begin
        fails++;
        $display("[TB] FAIL strobe shape: length_valid=%0b period_valid=%0b prev=%0b/%0b, required isolated single strobes",
                 length_valid, period_valid, prev_lv, prev_pv);
      end
    end
    prev_lv = length_valid;
    prev_pv = period_valid;
  end

  task automatic applyStimulus(input logic lvl, input int cycles);
    pwm_in = lvl;
    repeat (cycles) @(negedge clk0);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    asserts++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // exp value < 0 means no strobe of that kind is expected.
  task automatic checkStrobes(input string tag, input int exp_len, input int exp_per);
    checkOutput({tag, " length strobes"}, len_q.size(), (exp_len < 0) ? 0 : 1);
    if (exp_len >= 0 && len_q.size() > 0) checkOutput({tag, " length"}, len_q[0], exp_len);
    checkOutput({tag, " period strobes"}, per_q.size(), (exp_per < 0) ? 0 : 1);
    if (exp_per >= 0 && per_q.size() > 0) checkOutput({tag, " period"}, per_q[0], exp_per);
    len_q.delete();
    per_q.delete();
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    vecs[0] = '{1200, 2000, 150,  -1};
    vecs[1] = '{1200, 2000, 150, 400};
    vecs[2] = '{1200, 2000, 150, 400};
    vecs[3] = '{ 247, 2000,  30, 400};
    vecs[4] = '{ 248, 2000,  31, 280};
    vecs[5] = '{ 600,  600,  75, 281};

    repeat (4) @(negedge clk0);
    checkOutput("reset length", int'(length), 0);
    checkOutput("reset period", int'(period), 0);
    checkOutput("reset length_valid", int'(length_valid), 0);
    checkOutput("reset period_valid", int'(period_valid), 0);
    checkOutput("reset timeout", int'(timeout), 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 20);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].high_cyc);
      applyStimulus(1'b0, vecs[i].low_cyc);
      checkStrobes($sformatf("vec%0d", i), vecs[i].exp_len, vecs[i].exp_per);
      checkOutput($sformatf("vec%0d timeout", i), int'(timeout), 0);
    end
    checkOutput("held length", int'(length), 75);
    checkOutput("held period", int'(period), 281);

    $display("[TB] timeout after long low");
    applyStimulus(1'b1, 600);
    applyStimulus(1'b0, LAT + 3400);
    checkOutput("timeout before limit", int'(timeout), 0);
    applyStimulus(1'b0, 1);
    checkOutput("timeout at limit", int'(timeout), 1);
    applyStimulus(1'b0, 4800 - LAT - 3401);
    checkStrobes("timeout frame", 75, 150);
    checkOutput("stale length", int'(length), 75);
    checkOutput("stale period", int'(period), 150);
    applyStimulus(1'b1, LAT);
    checkOutput("timeout held until rise", int'(timeout), 1);
    applyStimulus(1'b1, 1);
    checkOutput("timeout cleared by rise", int'(timeout), 0);
    applyStimulus(1'b1, 800 - LAT - 1);
    applyStimulus(1'b0, 400);
    checkStrobes("after timeout", 100, -1);

    $display("[TB] stuck high");
    applyStimulus(1'b1, 4800);
    checkOutput("stuck high timeout", int'(timeout), 1);
    checkStrobes("stuck high", -1, 150);
    applyStimulus(1'b0, 400);
    checkOutput("timeout after idle fall", int'(timeout), 1);
    checkStrobes("fall in idle", -1, -1);
    applyStimulus(1'b1, 800);
    applyStimulus(1'b0, 400);
    checkStrobes("after stuck", 100, -1);
    checkOutput("timeout after recovery", int'(timeout), 0);

    $display("[TB] 3-cycle glitch in low phase");
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 400);
`ifdef PWM_LEN_CAPTURE_FILTER_EN
    checkStrobes("glitch", -1, -1);
    applyStimulus(1'b1, 1600);
    applyStimulus(1'b0, 400);
    checkStrobes("post glitch", 200, 200);
`else
    checkStrobes("glitch", 0, 150);
    applyStimulus(1'b1, 1600);
    applyStimulus(1'b0, 400);
    checkStrobes("post glitch", 200, 50);
`endif

    $display("[TB] reset mid-pulse");
    applyStimulus(1'b1, 100);
    checkStrobes("pre reset", -1, 250);
    rst_n = 1'b0;
    applyStimulus(1'b1, 5);
    checkOutput("mid reset length", int'(length), 0);
    checkOutput("mid reset period", int'(period), 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 160);
    applyStimulus(1'b0, 400);
    checkStrobes("partial pulse", -1, -1);
    applyStimulus(1'b1, 800);
    applyStimulus(1'b0, 400);
    checkStrobes("after partial", 100, -1);
    checkOutput("final length", int'(length), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
